// File: rtl/ca_correlator.sv
// ca_correlator: single-channel C/A-code correlator for acquisition.
// Integrates 2-bit I/Q samples x local chip over one full code period.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin one integration (honoured in IDLE only)
//   s_valid/s_ready sample handshake; transfer = s_valid & s_ready
//   i_d1,i_d0       I sample: sign (1 = neg), magnitude (1 -> 3, 0 -> 1)
//   q_d1,q_d0       Q sample, same encoding
//   chip            local code chip (0 -> +1, 1 -> -1)
//   code_init       one-cycle reload strobe to the code generator
//   code_rd         advance strobe to the code generator (combinational)
//   busy            high in ARM, RUN, DONE
//   done            one-cycle pulse; acc_i/acc_q valid from this cycle
//   acc_i, acc_q    signed integrated results, held until next DONE
module ca_correlator #(
  parameter int SPC      = 4,
  parameter int CODE_LEN = 1023,
  parameter int ACC_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  input  logic                    i_d1,
  input  logic                    i_d0,
  input  logic                    q_d1,
  input  logic                    q_d0,
  input  logic                    chip,
  output logic                    s_ready,
  output logic                    code_init,
  output logic                    code_rd,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] acc_q
);

  localparam int SW = (SPC > 1) ? $clog2(SPC) : 1;
  localparam int CW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  localparam logic [SW-1:0] SAMP_LAST = SW'(SPC - 1);
  localparam logic [CW-1:0] CHIP_LAST = CW'(CODE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [SW-1:0] samp_cnt;
  logic [CW-1:0] chip_cnt;

  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic signed [ACC_W-1:0] prod_i;
  logic signed [ACC_W-1:0] prod_q;
  logic signed [ACC_W-1:0] nxt_i;
  logic signed [ACC_W-1:0] nxt_q;

  logic xfer;
  logic last_samp;
  logic last_chip;

  // sample x chip: magnitude 1 or 3, negative when
  // sample sign and chip sign differ
  function automatic logic signed [ACC_W-1:0] term(
    input logic sgn,
    input logic mag
  );
    logic signed [ACC_W-1:0] m;
    m = mag ? ACC_W'(3) : ACC_W'(1);
    return sgn ? -m : m;
  endfunction

  // s_ready is a registered copy of (state == RUN)
  assign xfer      = s_ready & s_valid;
  assign last_samp = (samp_cnt == SAMP_LAST);
  assign last_chip = (chip_cnt == CHIP_LAST);

  // no advance after the final chip: the generator
  // is reloaded for the next integration instead
  assign code_rd = xfer & last_samp & ~last_chip;

  assign prod_i = term(i_d1 ^ chip, i_d0);
  assign prod_q = term(q_d1 ^ chip, q_d0);
  assign nxt_i  = sum_i + prod_i;
  assign nxt_q  = sum_q + prod_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      samp_cnt  <= '0;
      chip_cnt  <= '0;
      sum_i     <= '0;
      sum_q     <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      s_ready   <= 1'b0;
      code_init <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            samp_cnt  <= '0;
            chip_cnt  <= '0;
            sum_i     <= '0;
            sum_q     <= '0;
            code_init <= 1'b1;
            busy      <= 1'b1;
            state     <= ARM;
          end
        end
        ARM: begin
          code_init <= 1'b0;
          s_ready   <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (xfer) begin
            sum_i <= nxt_i;
            sum_q <= nxt_q;
            if (last_samp) begin
              samp_cnt <= '0;
              if (last_chip) begin
                acc_i   <= nxt_i;
                acc_q   <= nxt_q;
                s_ready <= 1'b0;
                done    <= 1'b1;
                state   <= DONE;
              end else begin
                chip_cnt <= chip_cnt + CW'(1);
              end
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ca_correlator.sv
// tb_ca_correlator: directed bench for ca_correlator.
// Per-cycle transfer-count model plus hand-computed sums.
module tb_ca_correlator;

  localparam int SPC   = 4;
  localparam int LEN   = 1023;
  localparam int ACC_W = 16;
  localparam int NXF   = SPC * LEN;

  logic clk;
  logic rst;
  logic start;
  logic s_valid;
  logic i_d1, i_d0, q_d1, q_d0;
  logic chip;
  logic s_ready, code_init, code_rd, busy, done;
  logic signed [ACC_W-1:0] acc_i, acc_q;

  // stimulus knobs
  logic i_s, i_m, q_s, q_m;
  int   chip_mode;
  logic rep;
  logic gap;

  logic code [LEN];
  int   idx;
  int   cyc;
  int   checks;
  int   errors;
  int   rd_cnt, done_cnt, init_cnt;
  int   t0;
  int   lat;
  int   bal;

  // model state
  int m_ph;
  int m_n;
  int m_si, m_sq;
  int m_ai, m_aq;

  ca_correlator #(
    .SPC(SPC),
    .CODE_LEN(LEN),
    .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .s_valid(s_valid),
    .i_d1(i_d1),
    .i_d0(i_d0),
    .q_d1(q_d1),
    .q_d0(q_d0),
    .chip(chip),
    .s_ready(s_ready),
    .code_init(code_init),
    .code_rd(code_rd),
    .busy(busy),
    .done(done),
    .acc_i(acc_i),
    .acc_q(acc_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // local code source reacting to the DUT strobes
  always @(posedge clk) begin
    if (code_init) idx <= 0;
    else if (code_rd) idx <= idx + 1;
  end

  always_comb begin
    chip = 1'b0;
    if (chip_mode == 1) chip = idx[0];
    else if (chip_mode == 2) chip = code[idx % LEN];
  end

  assign i_d1 = rep ? chip : i_s;
  assign i_d0 = i_m;
  assign q_d1 = q_s;
  assign q_d0 = q_m;

  initial begin
    s_valid = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (gap) s_valid = ~s_valid;
      else s_valid = 1'b1;
    end
  end

  function automatic int sval(input logic s, input logic m);
    int v;
    v = m ? 3 : 1;
    return s ? -v : v;
  endfunction

  // compare + model step on every falling edge
  always @(negedge clk) begin
    logic e_rd;
    int   vi, vq, c;
    e_rd = (m_ph == 2) && s_valid &&
           (m_n % SPC == SPC - 1) &&
           (m_n / SPC != LEN - 1);
    checks++;
    if (s_ready !== (m_ph == 2) ||
        code_init !== (m_ph == 1) ||
        busy !== (m_ph != 0) ||
        done !== (m_ph == 3) ||
        code_rd !== e_rd ||
        int'(acc_i) != m_ai ||
        int'(acc_q) != m_aq) begin
      errors++;
      $display("FAIL cycle %0d: rdy/ini/bsy/dn/rd=%b%b%b%b%b acc=%0d/%0d, need %b%b%b%b%b acc=%0d/%0d",
               cyc, s_ready, code_init, busy, done, code_rd,
               acc_i, acc_q, m_ph == 2, m_ph == 1, m_ph != 0,
               m_ph == 3, e_rd, m_ai, m_aq);
    end
    if (code_rd) rd_cnt++;
    if (done) done_cnt++;
    if (code_init) init_cnt++;
    if (rst) begin
      m_ph = 0; m_n = 0; m_si = 0; m_sq = 0;
      m_ai = 0; m_aq = 0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_ph = 1; m_n = 0; m_si = 0; m_sq = 0;
        end
        1: m_ph = 2;
        2: if (s_valid) begin
          c  = chip ? -1 : 1;
          vi = sval(i_d1, i_d0) * c;
          vq = sval(q_d1, q_d0) * c;
          m_si += vi;
          m_sq += vq;
          m_n++;
          if (m_n == NXF) begin
            m_ph = 3; m_ai = m_si; m_aq = m_sq;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_start();
    rd_cnt = 0;
    done_cnt = 0;
    @(posedge clk);
    #1 start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // wait for done; optional start pulse mid-run
  task automatic wait_done(input int mid, output int l);
    l = -1;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (done) begin
        l = cyc - t0;
        break;
      end
      start = (k == mid);
    end
    start = 1'b0;
    if (l < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic set_const();
    rep = 1'b0; chip_mode = 0;
    i_s = 1'b0; i_m = 1'b1;
    q_s = 1'b1; q_m = 1'b0;
  endtask

  initial begin
    logic [10:1] g1, g2;
    logic f1, f2;
    g1 = '1;
    g2 = '1;
    bal = 0;
    for (int i = 0; i < LEN; i++) begin
      code[i] = g1[10] ^ g2[2] ^ g2[6];
      bal += code[i] ? -1 : 1;
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      g1 = {g1[9:1], f1};
      g2 = {g2[9:1], f2};
    end
  end

  initial begin
    cyc = 0; idx = 0; checks = 0; errors = 0;
    rd_cnt = 0; done_cnt = 0; init_cnt = 0;
    m_ph = 0; m_n = 0; m_si = 0; m_sq = 0; m_ai = 0; m_aq = 0;
    gap = 1'b0;
    set_const();
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_acc_i", int'(acc_i), 0);
    chk("rst_init", init_cnt, 0);

    // constant input
    do_start();
    wait_done(-1, lat);
    chk("const_lat", lat, 4094);
    chk("const_acc_i", int'(acc_i), 12276);
    chk("const_acc_q", int'(acc_q), -4092);
    chk("const_rd", rd_cnt, 1022);
    @(negedge clk);
    chk("const_done_cnt", done_cnt, 1);
    chk("const_busy_off", int'(busy), 0);

    // alternating code; start during DONE ignored,
    // next IDLE start honoured
    chip_mode = 1;
    rd_cnt = 0;
    done_cnt = 0;
    @(posedge clk);
    #1 start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(-1, lat);
    chk("alt_lat", lat, 4094);
    chk("alt_acc_i", int'(acc_i), 12);
    chk("alt_acc_q", int'(acc_q), -4);
    start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    chip_mode = 0;
    wait_done(-1, lat);
    chk("b2b_lat", lat, 4094);
    chk("b2b_acc_i", int'(acc_i), 12276);

    // flow control
    gap = 1'b1;
    do_start();
    wait_done(-1, lat);
    gap = 1'b0;
    chk("gap_acc_i", int'(acc_i), 12276);
    chk("gap_acc_q", int'(acc_q), -4092);
    chk("gap_rd", rd_cnt, 1022);
    chk("gap_long", int'(lat > 8180), 1);

    // start pulsed mid-run
    do_start();
    wait_done(1000, lat);
    chk("mid_lat", lat, 4094);
    chk("mid_acc_i", int'(acc_i), 12276);

    // reset at chip 500
    do_start();
    repeat (2002) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_acc_i", int'(acc_i), 0);
    chk("abort_acc_q", int'(acc_q), 0);
    done_cnt = 0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    do_start();
    wait_done(-1, lat);
    chk("recov_acc_i", int'(acc_i), 12276);
    chk("recov_acc_q", int'(acc_q), -4092);

    // real Gold code, I follows replica
    chip_mode = 2;
    rep = 1'b1;
    i_m = 1'b0;
    q_s = 1'b0; q_m = 1'b0;
    do_start();
    wait_done(-1, lat);
    chk("gold_acc_i", int'(acc_i), 4092);
    chk("gold_acc_q", int'(acc_q), 4 * bal);
    chk("gold_rd", rd_cnt, 1022);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
